fifo_uart_tx: RTL and testbench

Byte serializer draining the 1 KB byte FIFO on its read side. Pops one byte whenever the FIFO is non-empty and the line is idle, then shifts it out as an 8N1 UART frame, LSB first, at a fixed clocks-per-bit rate. Sits between the FIFO's `rd_en`/`empty`/`dout` port and the board TX pin; the only consumer of the FIFO output.

---
 rtl/fifo_uart_tx.sv | 137 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a FIFO and sends each one as an 8N1 or 8N2 frame, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1/8E2).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);
  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, rd_n, busy_n, done_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      tx         <= tx_n;
      fifo_rd_en <= rd_n;
      busy       <= busy_n;
      tx_done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx;
    rd_n    = 1'b0;
    busy_n  = busy;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd_n    = 1'b1;
          busy_n  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shreg_n = fifo_dout;
        tx_n    = 1'b0;
        cnt_n   = '0;
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_n    = ^shreg;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            idx_n   = '0;
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shreg[idx + 3'd1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            idx_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx_done is registered, so it is raised when the next cycle is the final stop cycle
  assign done_n = (state_n == STOP) && (idx_n == STOP_LAST) && (cnt_n == CNT_LAST);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: a FIFO model drives the DUT, and every cycle the outputs are compared
// with a frame-timeline reference; a line decoder checks frame length, gaps and the received bytes.
module tb_fifo_uart_tx;
  localparam int C = 4;
  localparam int S = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = (9 + S + P) * C;

  logic       clk = 1'b0, rst = 1'b0, fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, tx, busy, tx_done;

  int tests = 0, fails = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(S)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // FIFO model: dout updates the cycle after rd_en is sampled
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic       pend = 1'b0;
  initial forever begin
    @(negedge clk);
    if (pend && q.size() > 0) fifo_dout = q.pop_front();
    pend       = fifo_rd_en;
    fifo_empty = (q.size() == 0);
  end

  task automatic push(logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Reference: k counts cycles since the pop decision; frame starts at k=3
  bit         active = 1'b0;
  int         k = 0;
  logic [7:0] cur = 8'h00;
  initial forever begin
    @(posedge clk);
    if (rst) active = 1'b0;
    else if (active) begin
      k++;
      if (k == L + 3) active = 1'b0;
    end else if (!fifo_empty) begin
      active = 1'b1;
      k      = 1;
      cur    = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    end
  end

  function automatic logic [3:0] exp_out();
    int   p, b;
    logic t;
    if (rst || !active) return 4'b1000;
    p = k - 3;
    if (k < 3) t = 1'b1;
    else begin
      b = p / C;
      if (b == 0)                t = 1'b0;
      else if (b <= 8)           t = cur[b-1];
      else if (P == 1 && b == 9) t = ^cur;
      else                       t = 1'b1;
    end
    return {t, (k == 1), 1'b1, (k >= 3 && p == L - 1)};
  endfunction

  // Compare process plus line decoder
  int         cyc = 0, fall_cyc = -1, last_done = -1;
  int         n_done = 0, n_pop = 0, n_fall = 0, n_gap3 = 0, flen = 0;
  logic       prev_tx = 1'b1, par = 1'b0;
  logic [7:0] rxb = 8'h00;
  logic [7:0] rx_q[$];
  initial forever begin
    int rel;
    @(negedge clk);
    cyc++;
    check("outputs{tx,rd_en,busy,tx_done}", {tx, fifo_rd_en, busy, tx_done}, exp_out());
    if (fifo_rd_en) n_pop++;
    if (rst) begin
      fall_cyc  = -1;
      last_done = -1;
    end else begin
      if (fall_cyc < 0 && prev_tx && !tx) begin
        fall_cyc = cyc;
        rxb      = 8'h00;
        n_fall++;
        if (last_done >= 0 && cyc - last_done - 1 == 3) n_gap3++;
      end
      if (fall_cyc >= 0) begin
        rel = cyc - fall_cyc;
        for (int i = 0; i < 8; i++) if (rel == C * (i + 1) + C / 2) rxb[i] = tx;
        if (rel == 9 * C + C / 2) par = tx;
        if (tx_done) begin
          flen = rel + 1;
          rx_q.push_back(rxb);
          n_done++;
          last_done = cyc;
          fall_cyc  = -1;
        end
      end
    end
    prev_tx = tx;
  end

  task automatic wait_done(int target, int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_done < target) check("timeout_tx_done", n_done, target);
  endtask

  task automatic wait_fall(int target, int budget);
    int n = 0;
    while (n_fall < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_fall < target) check("timeout_start_bit", n_fall, target);
  endtask

  task automatic idle_cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rexp[$];
    int         base;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycles(6);
    check("no_pop_after_reset", n_pop, 0);
    check("no_done_after_reset", n_done, 0);

    // single byte
    push(8'hA5);
    wait_done(1, 200);
    check("a5_pops", n_pop, 1);
    check("a5_frame_len", flen, (P == 1) ? 44 : 40);
    check("a5_byte", rx_q[rx_q.size()-1], 8'hA5);
    idle_cycles(10);

    // back to back
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_done(4, 600);
    check("b2b_byte0", rx_q[1], 8'h00);
    check("b2b_byte1", rx_q[2], 8'hFF);
    check("b2b_byte2", rx_q[3], 8'h3C);
    check("b2b_pops", n_pop, 4);
    check("b2b_gaps_of_3", n_gap3, 2);
    idle_cycles(10);

    // reset during data bit 3 of 0x55; 0x12 stays queued
    push(8'h55); push(8'h12);
    wait_fall(n_fall + 1, 100);
    repeat (17) @(posedge clk);
    #2;
    check("tx_bit3_before_reset", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("tx_high_on_reset", tx, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n_done;
    wait_done(base + 1, 300);
    check("after_reset_byte", rx_q[rx_q.size()-1], 8'h12);
    check("after_reset_frame_len", flen, L);
    idle_cycles(10);

    // randomized traffic with bursts and idle spans
    base = rx_q.size();
    for (int i = 0; i < 25; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      push(b);
      rexp.push_back(b);
      idle_cycles($urandom_range(0, 60));
    end
    wait_done(n_done + exp_q.size() + (active ? 1 : 0), 3000);
    for (int i = 0; i < 25; i++)
      check("random_byte", (base + i < rx_q.size()) ? rx_q[base+i] : 9'h100, rexp[i]);

`ifdef UART_TX_PARITY_EN
    idle_cycles(10);
    push(8'h07);
    wait_done(n_done + 1, 300);
    check("parity_07", par, 1'b1);
    check("parity_frame_len", flen, 44);
    push(8'h03);
    wait_done(n_done + 1, 300);
    check("parity_03", par, 1'b0);
`endif

    idle_cycles(5);
    check("fifo_drained", q.size(), 0);
    check("pops_match_frames", n_pop, n_done + 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
